// File: rtl/agg_oq_arbiter.sv
// Packet-granular round-robin merge of the aggregation result stream and the parser bypass stream.
// Optional per-input packet counters are enabled with `define AGG_OQ_ARBITER_STATS_EN.
module agg_oq_arbiter #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_agg_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_agg_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_agg_tuser,
  input  logic                            s_axis_agg_tvalid,
  input  logic                            s_axis_agg_tlast,
  output logic                            s_axis_agg_tready,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_byp_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_byp_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_byp_tuser,
  input  logic                            s_axis_byp_tvalid,
  input  logic                            s_axis_byp_tlast,
  output logic                            s_axis_byp_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
`ifdef AGG_OQ_ARBITER_STATS_EN
  ,
  output logic [31:0]                     pkt_cnt_agg,
  output logic [31:0]                     pkt_cnt_byp
`endif
);

  typedef enum logic [1:0] {StIdle, StSendAgg, StSendByp} state_e;

  localparam logic GrantAgg = 1'b0;
  localparam logic GrantByp = 1'b1;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   agg_done, byp_done;

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    m_axis_tdata      = '0;
    m_axis_tkeep      = '0;
    m_axis_tuser      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    s_axis_agg_tready = 1'b0;
    s_axis_byp_tready = 1'b0;
    agg_done          = 1'b0;
    byp_done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On contention the input that did not win last time gets the grant.
        if (s_axis_agg_tvalid && (!s_axis_byp_tvalid || last_grant_q == GrantByp)) begin
          state_d      = StSendAgg;
          last_grant_d = GrantAgg;
        end else if (s_axis_byp_tvalid) begin
          state_d      = StSendByp;
          last_grant_d = GrantByp;
        end
      end
      StSendAgg: begin
        m_axis_tdata      = s_axis_agg_tdata;
        m_axis_tkeep      = s_axis_agg_tkeep;
        m_axis_tuser      = s_axis_agg_tuser;
        m_axis_tvalid     = s_axis_agg_tvalid;
        m_axis_tlast      = s_axis_agg_tlast;
        s_axis_agg_tready = m_axis_tready;
        agg_done          = s_axis_agg_tvalid & m_axis_tready & s_axis_agg_tlast;
        if (agg_done) state_d = StIdle;
      end
      StSendByp: begin
        m_axis_tdata      = s_axis_byp_tdata;
        m_axis_tkeep      = s_axis_byp_tkeep;
        m_axis_tuser      = s_axis_byp_tuser;
        m_axis_tvalid     = s_axis_byp_tvalid;
        m_axis_tlast      = s_axis_byp_tlast;
        s_axis_byp_tready = m_axis_tready;
        byp_done          = s_axis_byp_tvalid & m_axis_tready & s_axis_byp_tlast;
        if (byp_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q      <= StIdle;
      last_grant_q <= GrantByp;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef AGG_OQ_ARBITER_STATS_EN
  logic [31:0] cnt_agg_q, cnt_agg_d;
  logic [31:0] cnt_byp_q, cnt_byp_d;

  always_comb begin
    cnt_agg_d = cnt_agg_q + {31'd0, agg_done};
    cnt_byp_d = cnt_byp_q + {31'd0, byp_done};
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      cnt_agg_q <= '0;
      cnt_byp_q <= '0;
    end else begin
      cnt_agg_q <= cnt_agg_d;
      cnt_byp_q <= cnt_byp_d;
    end
  end

  assign pkt_cnt_agg = cnt_agg_q;
  assign pkt_cnt_byp = cnt_byp_q;
`endif

endmodule

// File: tb/tb_agg_oq_arbiter.sv
// Directed cycle-by-cycle bench for agg_oq_arbiter; each vector drives both inputs and checks
// the merged output and both readys. Counter checks are compiled with AGG_OQ_ARBITER_STATS_EN.
module tb_agg_oq_arbiter;

  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   agg_tdata, byp_tdata, m_tdata;
  logic [DW/8-1:0] agg_tkeep, byp_tkeep, m_tkeep;
  logic [UW-1:0]   agg_tuser, byp_tuser, m_tuser;
  logic            agg_tvalid, agg_tlast, agg_tready;
  logic            byp_tvalid, byp_tlast, byp_tready;
  logic            m_tvalid, m_tlast, m_tready;
`ifdef AGG_OQ_ARBITER_STATS_EN
  logic [31:0]     pkt_cnt_agg, pkt_cnt_byp;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  agg_oq_arbiter #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW)
  ) dut (
    .axis_aclk        (clk),
    .axis_reset       (rst),
    .s_axis_agg_tdata (agg_tdata),
    .s_axis_agg_tkeep (agg_tkeep),
    .s_axis_agg_tuser (agg_tuser),
    .s_axis_agg_tvalid(agg_tvalid),
    .s_axis_agg_tlast (agg_tlast),
    .s_axis_agg_tready(agg_tready),
    .s_axis_byp_tdata (byp_tdata),
    .s_axis_byp_tkeep (byp_tkeep),
    .s_axis_byp_tuser (byp_tuser),
    .s_axis_byp_tvalid(byp_tvalid),
    .s_axis_byp_tlast (byp_tlast),
    .s_axis_byp_tready(byp_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tuser     (m_tuser),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tlast     (m_tlast),
    .m_axis_tready    (m_tready)
`ifdef AGG_OQ_ARBITER_STATS_EN
    ,
    .pkt_cnt_agg      (pkt_cnt_agg),
    .pkt_cnt_byp      (pkt_cnt_byp)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus (byte pattern replicated across the buses), check, advance.
  task automatic cyc(input string tag,
                     input logic av, input logic [7:0] ad, input logic al,
                     input logic bv, input logic [7:0] bd, input logic bl,
                     input logic mr,
                     input logic ev, input logic [7:0] ed, input logic el,
                     input logic ear, input logic ebr);
    agg_tvalid = av; agg_tdata = {32{ad}}; agg_tkeep = {4{ad}}; agg_tuser = {16{ad}};
    agg_tlast  = al;
    byp_tvalid = bv; byp_tdata = {32{bd}}; byp_tkeep = {4{bd}}; byp_tuser = {16{bd}};
    byp_tlast  = bl;
    m_tready   = mr;
    #1;
    check_eq($sformatf("%s_tvalid", tag), 64'(m_tvalid), 64'(ev));
    check_eq($sformatf("%s_tdata", tag), m_tdata[63:0], {8{ed}});
    check_eq($sformatf("%s_tkeep", tag), 64'(m_tkeep), 64'({4{ed}}));
    check_eq($sformatf("%s_tuser", tag), m_tuser[63:0], {8{ed}});
    check_eq($sformatf("%s_tlast", tag), 64'(m_tlast), 64'(el));
    check_eq($sformatf("%s_agg_rdy", tag), 64'(agg_tready), 64'(ear));
    check_eq($sformatf("%s_byp_rdy", tag), 64'(byp_tready), 64'(ebr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    agg_tvalid = 1'b1; agg_tdata = '0; agg_tkeep = '0; agg_tuser = '0; agg_tlast = 1'b0;
    byp_tvalid = 1'b1; byp_tdata = '0; byp_tkeep = '0; byp_tuser = '0; byp_tlast = 1'b0;
    m_tready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    //          tag         av ad     al  bv bd     bl  mr  ev ed     el  ar br
    cyc("rst",              1, 8'hA1, 0,  1, 8'hB1, 0,  1,  0, 8'h00, 0,  0, 0);
    rst = 1'b0;

    // Contention right after reset: AGG first, then alternate.
    cyc("rr_idle0",         1, 8'hA1, 0,  1, 8'hB1, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("rr_agg0_b1",       1, 8'hA1, 0,  1, 8'hB1, 0,  1,  1, 8'hA1, 0,  1, 0);
    cyc("rr_agg0_b2",       1, 8'hA2, 1,  1, 8'hB1, 0,  1,  1, 8'hA2, 1,  1, 0);
    cyc("rr_idle1",         1, 8'hA3, 0,  1, 8'hB1, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("rr_byp0_b1",       1, 8'hA3, 0,  1, 8'hB1, 0,  1,  1, 8'hB1, 0,  0, 1);
    cyc("rr_byp0_b2",       1, 8'hA3, 0,  1, 8'hB2, 1,  1,  1, 8'hB2, 1,  0, 1);
    cyc("rr_idle2",         1, 8'hA3, 0,  1, 8'hB3, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("rr_agg1_b1",       1, 8'hA3, 0,  1, 8'hB3, 0,  1,  1, 8'hA3, 0,  1, 0);
    cyc("rr_agg1_b2",       1, 8'hA4, 1,  1, 8'hB3, 0,  1,  1, 8'hA4, 1,  1, 0);
    cyc("rr_idle3",         0, 8'h00, 0,  1, 8'hB3, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("rr_byp1_b1",       0, 8'h00, 0,  1, 8'hB3, 0,  1,  1, 8'hB3, 0,  0, 1);
    cyc("rr_byp1_b2",       0, 8'h00, 0,  1, 8'hB4, 1,  1,  1, 8'hB4, 1,  0, 1);
    cyc("rr_idle4",         0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);

    // Bypass-only 4-beat packet, then a back-to-back single-beat packet.
    cyc("byp4_idle",        0, 8'h00, 0,  1, 8'hB5, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("byp4_b1",          0, 8'h00, 0,  1, 8'hB5, 0,  1,  1, 8'hB5, 0,  0, 1);
    cyc("byp4_b2",          0, 8'h00, 0,  1, 8'hB6, 0,  1,  1, 8'hB6, 0,  0, 1);
    cyc("byp4_b3",          0, 8'h00, 0,  1, 8'hB7, 0,  1,  1, 8'hB7, 0,  0, 1);
    cyc("byp4_b4",          0, 8'h00, 0,  1, 8'hB8, 1,  1,  1, 8'hB8, 1,  0, 1);
    cyc("b2b_bubble",       0, 8'h00, 0,  1, 8'hB9, 1,  1,  0, 8'h00, 0,  0, 0);
    cyc("b2b_single",       0, 8'h00, 0,  1, 8'hB9, 1,  1,  1, 8'hB9, 1,  0, 1);
    cyc("b2b_idle",         0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);

    // AGG 3-beat packet with a 5-cycle output stall on beat 2.
    cyc("stall_idle",       1, 8'hC1, 0,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("stall_b1",         1, 8'hC1, 0,  0, 8'h00, 0,  1,  1, 8'hC1, 0,  1, 0);
    for (int i = 0; i < 5; i++)
      cyc($sformatf("stall_hold%0d", i),
                            1, 8'hC2, 0,  0, 8'h00, 0,  0,  1, 8'hC2, 0,  0, 0);
    cyc("stall_b2",         1, 8'hC2, 0,  0, 8'h00, 0,  1,  1, 8'hC2, 0,  1, 0);
    cyc("stall_b3",         1, 8'hC3, 1,  0, 8'h00, 0,  1,  1, 8'hC3, 1,  1, 0);
    cyc("stall_idle2",      0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);

    // BYP granted (last grant was AGG), then goes invalid mid-packet while AGG waits.
    cyc("gap_idle",         1, 8'hD1, 1,  1, 8'hE1, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("gap_b1",           1, 8'hD1, 1,  1, 8'hE1, 0,  1,  1, 8'hE1, 0,  0, 1);
    cyc("gap_b2",           1, 8'hD1, 1,  1, 8'hE2, 0,  1,  1, 8'hE2, 0,  0, 1);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("gap_hole%0d", i),
                            1, 8'hD1, 1,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 1);
    cyc("gap_b3",           1, 8'hD1, 1,  1, 8'hE3, 1,  1,  1, 8'hE3, 1,  0, 1);
    cyc("gap_agg_idle",     1, 8'hD1, 1,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("gap_agg_b1",       1, 8'hD1, 1,  0, 8'h00, 0,  1,  1, 8'hD1, 1,  1, 0);
    cyc("gap_idle2",        0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);

`ifdef AGG_OQ_ARBITER_STATS_EN
    check_eq("cnt_agg_run", 64'(pkt_cnt_agg), 64'd4);
    check_eq("cnt_byp_run", 64'(pkt_cnt_byp), 64'd5);
`endif

    // Reset during beat 2 of a 5-beat AGG packet abandons it.
    cyc("rst_idle",         1, 8'hF1, 0,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("rst_b1",           1, 8'hF1, 0,  0, 8'h00, 0,  1,  1, 8'hF1, 0,  1, 0);
    rst = 1'b1;
    cyc("rst_b2",           1, 8'hF2, 0,  0, 8'h00, 0,  1,  1, 8'hF2, 0,  1, 0);
    cyc("rst_after",        1, 8'hF3, 0,  1, 8'h01, 0,  1,  0, 8'h00, 0,  0, 0);
`ifdef AGG_OQ_ARBITER_STATS_EN
    check_eq("cnt_agg_rst", 64'(pkt_cnt_agg), 64'd0);
    check_eq("cnt_byp_rst", 64'(pkt_cnt_byp), 64'd0);
`endif
    rst = 1'b0;
    cyc("rst_rel_idle",     1, 8'hF3, 1,  1, 8'h01, 1,  1,  0, 8'h00, 0,  0, 0);
    cyc("rst_rel_agg",      1, 8'hF3, 1,  1, 8'h01, 1,  1,  1, 8'hF3, 1,  1, 0);
    cyc("rst_rel_idle2",    0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);

`ifdef AGG_OQ_ARBITER_STATS_EN
    check_eq("cnt_agg_post", 64'(pkt_cnt_agg), 64'd1);
    force dut.cnt_agg_q = 32'hFFFF_FFFF;
    force dut.cnt_byp_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_agg_q;
    release dut.cnt_byp_q;
    cyc("wrap_agg_idle",    1, 8'h5A, 1,  0, 8'h00, 0,  1,  0, 8'h00, 0,  0, 0);
    cyc("wrap_agg_send",    1, 8'h5A, 1,  0, 8'h00, 0,  1,  1, 8'h5A, 1,  1, 0);
    check_eq("cnt_agg_wrap", 64'(pkt_cnt_agg), 64'd0);
    check_eq("cnt_byp_hold", 64'(pkt_cnt_byp), 64'hFFFF_FFFF);
    cyc("wrap_byp_idle",    0, 8'h00, 0,  1, 8'h5B, 1,  1,  0, 8'h00, 0,  0, 0);
    cyc("wrap_byp_send",    0, 8'h00, 0,  1, 8'h5B, 1,  1,  1, 8'h5B, 1,  0, 1);
    check_eq("cnt_byp_wrap", 64'(pkt_cnt_byp), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/agg_oq_arbiter.md
AGG_OQ_ARBITER -- requirements
Module: agg_oq_arbiter

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256, tdata width of all streams.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, tuser width of all streams.
REQ-003 SHALL have port axis_aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port axis_reset, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports s_axis_agg_tdata/tkeep/tuser/tvalid/tlast, inputs, widths DATA/DATA÷8/TUSER/1/1, aggregation-pipeline result stream.
REQ-006 SHALL have port s_axis_agg_tready, output, 1, ready to the aggregation pipeline.
REQ-007 SHALL have ports s_axis_byp_tdata/tkeep/tuser/tvalid/tlast, inputs, widths DATA/DATA÷8/TUSER/1/1, parser bypass (non-aggregated) stream.
REQ-008 SHALL have port s_axis_byp_tready, output, 1, ready to the parser bypass port.
REQ-009 SHALL have ports m_axis_tdata/tkeep/tuser/tvalid/tlast, outputs, widths DATA/DATA÷8/TUSER/1/1, merged stream to output queues.
REQ-010 SHALL have port m_axis_tready, input, 1, ready from output queues.

Function
REQ-011 SHALL arbitrate at packet granularity; beats of two packets never interleave on m_axis.
REQ-012 SHALL implement states IDLE, SEND_AGG, SEND_BYP.
REQ-013 In IDLE: m_axis_tvalid=0, both s_*_tready=0; the grant decision is registered; first beat appears on m_axis no earlier than the cycle after the decision (one bubble per packet).
REQ-014 IDLE, only agg tvalid=1 -> SEND_AGG; only byp tvalid=1 -> SEND_BYP; neither -> stay IDLE.
REQ-015 IDLE, both tvalid=1 -> grant the input not recorded in last_grant (round-robin); last_grant is updated to the granted input on the IDLE->SEND transition.
REQ-016 In SEND_x: m_axis_tdata/tkeep/tuser/tlast/tvalid = s_axis_x equivalents combinationally; s_axis_x_tready = m_axis_tready; the other input's tready=0.
REQ-017 In SEND_x, beat transfer = m_axis_tvalid & m_axis_tready; transfer with tlast=1 -> IDLE next cycle; otherwise remain.
REQ-018 SEND_x with s_axis_x_tvalid=0 mid-packet SHALL hold state (no timeout) and drive m_axis_tvalid=0.
REQ-019 m_axis_tdata/tkeep/tuser/tlast SHALL be driven to 0 in IDLE.
REQ-020 A single-beat packet (tlast on first beat) SHALL complete in one SEND cycle when m_axis_tready=1.
REQ-021 Back-to-back packets on the same input with the other idle SHALL each cost exactly one IDLE bubble cycle.

Reset
REQ-022 On axis_reset=1 at a clock edge: state=IDLE, last_grant=BYP (first contended grant goes to AGG), all stats counters=0.
REQ-023 During and after reset until a grant: m_axis_tvalid=0, s_axis_agg_tready=0, s_axis_byp_tready=0.
REQ-024 Reset asserted mid-packet SHALL abandon the packet; no completion of it is attempted afterwards.

Configuration
REQ-025 Macro AGG_OQ_ARBITER_STATS_EN: when defined, block SHALL add output ports pkt_cnt_agg and pkt_cnt_byp, 32 bits each, incremented by 1 on each tlast transfer from that input, wrapping 0xFFFFFFFF->0, cleared by reset.
REQ-026 Without AGG_OQ_ARBITER_STATS_EN the counter ports and logic SHALL be absent; arbitration behaviour is identical.

Verification
REQ-027 Only byp sends a 4-beat packet, m_axis_tready=1 -> 1 bubble, 4 beats on m_axis in consecutive cycles, tlast on beat 4, agg tready stays 0.
REQ-028 After reset both inputs present 2-beat packets simultaneously -> AGG packet first, then 1 bubble, then BYP; repeat -> order AGG, BYP, AGG, BYP.
REQ-029 Grant AGG, 3-beat packet, m_axis_tready=0 for 5 cycles mid-packet -> data held, s_axis_agg_tready=0 during stall, no beat lost or duplicated.
REQ-030 BYP deasserts tvalid for 3 cycles between beats 2 and 3 while AGG has tvalid=1 -> state stays SEND_BYP, AGG not granted until BYP tlast accepted.
REQ-031 Assert axis_reset during beat 2 of a 5-beat packet -> next cycle m_axis_tvalid=0, both treadys 0, state IDLE.
REQ-032 With AGG_OQ_ARBITER_STATS_EN, preload-free run of 3 AGG and 2 BYP packets -> pkt_cnt_agg=3, pkt_cnt_byp=2; counters forced near 0xFFFFFFFF wrap to 0.
